sram_req_ctrl: RTL and testbench
================================

Name: sram_req_ctrl

Overview:
Initiator-side controller for the unit SRAM port (sram_clk, addr, d_in, c, wen, ren, reg_out, d_out). It turns a valid/ready request stream from client logic into single-cycle SRAM wen/ren commands and captures read data at the correct SRAM read latency. Read data is returned through a credit-protected response FIFO, so no read result is ever dropped. It sits between the audio sample datapath and the SRAM macro.

Parameters:
ADDR_W, 15, SRAM word address width
DATA_W, 32, SRAM data width
MODE_W, 3, width of the SRAM access-mode field (c)
RSP_DEPTH, 4, response FIFO depth, which is also the maximum number of reads in flight plus buffered

Ports:
sram_clk  in  1  clock, shared with the SRAM
sram_rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready at a sram_clk rising edge
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
req_mode  in  MODE_W  access mode, forwarded to SRAM c
rsp_valid  out  1  read response available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_W  read data
reg_out_sel  in  1  static SRAM output-register select, driven to the SRAM reg_out pin
busy  out  1  reads in flight or response FIFO non-empty
sram_addr  out  ADDR_W  to SRAM addr
sram_d_in  out  DATA_W  to SRAM d_in
sram_c  out  MODE_W  to SRAM c
sram_wen  out  1  to SRAM wen
sram_ren  out  1  to SRAM ren
sram_reg_out  out  1  equals reg_out_sel
sram_d_out  in  DATA_W  from SRAM d_out

Behaviour:
- Reset (async assert, sync deassert by the user): sram_wen, sram_ren, sram_addr, sram_d_in, sram_c, rsp_valid, rsp_rdata and busy are all 0. FIFO is empty, in-flight pipe is cleared, credits = RSP_DEPTH.
- Reset during an operation discards all in-flight reads and buffered responses. No response is produced for them.
- Credits = RSP_DEPTH - (FIFO occupancy + reads in flight). req_ready = (credits != 0), for both reads and writes, and does not depend on req_valid or req_we.
- Issue: a request accepted at edge T drives the registered sram_* outputs, with wen or ren = 1, for exactly the cycle after T. With no accept, wen = ren = 0 and addr/d_in/c hold their values. At most one command per cycle, and wen and ren are never both 1.
- Read capture uses an in-flight valid shift register of depth 2. For a read accepted at edge T:
  - reg_out_sel = 0: sram_d_out is sampled at edge T+2, and rsp_valid = 1 after edge T+2.
  - reg_out_sel = 1: sram_d_out is sampled at edge T+3, and rsp_valid = 1 after edge T+3.
- Responses are returned in request order. Writes never generate a response.
- A read accepted at edge T+1, right after a write at edge T to the same address, returns the new data. The SRAM orders this, and the controller adds nothing.
- FIFO full with credits at 0: req_ready = 0.
- Simultaneous push and pop on a full FIFO: legal. Occupancy is unchanged and the credit returns on the pop.
- Simultaneous accept and credit return: the count updates net (-1 +1).
- Empty FIFO: rsp_valid = 0 and rsp_rdata holds its last value.
- reg_out_sel may change only while busy = 0. A change while busy is unsupported, and the SVA flags it.
- Counters are sized clog2(RSP_DEPTH+1) and wrap never occurs by construction.

Optional Feature:
SRAM_CTRL_STATS_EN: when defined, adds output ports rd_count[15:0] and wr_count[15:0]. Each counts accepted reads/writes, saturates at 16'hFFFF, and resets to 0. When undefined, these ports and their logic are absent and all other behaviour is identical.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the ADDR_W, DATA_W and MODE_W defaults;
  - mode encodings MODE_WORD = 3'b000, MODE_HALF = 3'b001, MODE_BYTE = 3'b010, MODE_NIBBLE = 3'b011;
  - read-latency constants RD_LAT_NOREG = 2 and RD_LAT_REG = 3, in accept-to-capture edges.
- One sub-module, sram_rsp_fifo: a synchronous FIFO of RSP_DEPTH x DATA_W with push/pop/full/empty/count outputs and async active-low reset.

Test Plan:
- Write 32'h0005FFAB to addr 0, mode 3'b000, then read addr 0 with reg_out_sel = 0 -> sram_wen pulses 1 cycle; rsp_valid rises after edge T+2 with rsp_rdata = 32'h0005FFAB.
- Same sequence with reg_out_sel = 1 -> rsp_valid rises after edge T+3 with the same data; busy = 1 from accept until pop.
- Write 32'hB2 to addr 2 with req_mode = 3'b010, then 32'hF to addr 12 with mode 3'b011 -> sram_c / sram_addr / sram_d_in equal 010/2/B2 then 011/12/F on the issue cycles.
- rsp_ready = 0 with 6 back-to-back reads -> exactly 4 accepted, then req_ready = 0. Raising rsp_ready for one cycle -> one pop and exactly one more accept. Responses come out in address order.
- FIFO full with rsp_ready = 1 and req_valid = 1 every cycle -> sustained 1 read/cycle throughput once primed, and no lost or duplicated data.
- Assert sram_rst_n low 1 cycle after a read is accepted -> all outputs 0 immediately, no rsp_valid after reset, credits = 4, and a fresh read works.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared widths, SRAM access-mode encodings and read latencies for the SRAM request controller.
// Helpers here are also used by the optional SRAM_CTRL_STATS_EN counters.
package sram_ctrl_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_MODE_W = 3;

    localparam logic [2:0] MODE_WORD   = 3'b000;
    localparam logic [2:0] MODE_HALF   = 3'b001;
    localparam logic [2:0] MODE_BYTE   = 3'b010;
    localparam logic [2:0] MODE_NIBBLE = 3'b011;

    // Accept edge to capture edge, with and without the SRAM output register.
    localparam int RD_LAT_NOREG = 2;
    localparam int RD_LAT_REG   = 3;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: DEPTH x DATA_W response FIFO; a push on a full FIFO is taken only together with a pop.
// While empty, rdata holds the last word popped (0 after reset).
module sram_rsp_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] last;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == CNT_W'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? last : mem[rd_ptr];

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= nxt(wr_ptr);
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
                last   <= mem[rd_ptr];
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: turns a valid/ready request stream into registered SRAM wen/ren commands and returns read data through a credit-protected FIFO.
// Define SRAM_CTRL_STATS_EN to add saturating rd_count/wr_count outputs.
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MODE_W    = DEF_MODE_W,
    parameter int RSP_DEPTH = 4
) (
    input  logic              sram_clk,
    input  logic              sram_rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MODE_W-1:0] req_mode,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              reg_out_sel,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_d_in,
    output logic [MODE_W-1:0] sram_c,
    output logic              sram_wen,
    output logic              sram_ren,
    output logic              sram_reg_out,
    input  logic [DATA_W-1:0] sram_d_out
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic             accept, rd_acc, pop, capture;
    logic [1:0]       rd_pipe;
    logic [CNT_W-1:0] used, fifo_count;
    logic             fifo_full, fifo_empty;

    // used = reads in flight + buffered responses; credits are RSP_DEPTH - used.
    assign req_ready    = used != CNT_W'(RSP_DEPTH);
    assign accept       = req_valid && req_ready;
    assign rd_acc       = accept && !req_we;
    assign pop          = rsp_valid && rsp_ready;
    assign rsp_valid    = !fifo_empty;
    assign busy         = used != '0;
    assign sram_reg_out = reg_out_sel;
    assign capture      = reg_out_sel ? rd_pipe[RD_LAT_REG - RD_LAT_NOREG] : rd_pipe[0];

    always_ff @(posedge sram_clk or negedge sram_rst_n) begin
        if (!sram_rst_n) begin
            sram_wen  <= 1'b0;
            sram_ren  <= 1'b0;
            sram_addr <= '0;
            sram_d_in <= '0;
            sram_c    <= '0;
            rd_pipe   <= '0;
            used      <= '0;
        end else begin
            sram_wen <= accept && req_we;
            sram_ren <= rd_acc;
            if (accept) begin
                sram_addr <= req_addr;
                sram_d_in <= req_wdata;
                sram_c    <= req_mode;
            end
            rd_pipe <= {rd_pipe[0], sram_ren};
            used    <= used + CNT_W'(rd_acc) - CNT_W'(pop);
        end
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .DATA_W(DATA_W)
    ) u_rsp_fifo (
        .clk  (sram_clk),
        .rst_n(sram_rst_n),
        .push (capture),
        .wdata(sram_d_out),
        .pop  (pop),
        .rdata(rsp_rdata),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

`ifdef SRAM_CTRL_STATS_EN
    always_ff @(posedge sram_clk or negedge sram_rst_n) begin
        if (!sram_rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            rd_count <= rd_acc ? sat_inc(rd_count) : rd_count;
            wr_count <= (accept && req_we) ? sat_inc(wr_count) : wr_count;
        end
    end
`endif

    a_one_cmd: assert property (@(posedge sram_clk) disable iff (!sram_rst_n)
        !(sram_wen && sram_ren));
    a_reg_sel_static: assert property (@(posedge sram_clk) disable iff (!sram_rst_n)
        busy |-> $stable(reg_out_sel));
    a_credit_cover: assert property (@(posedge sram_clk) disable iff (!sram_rst_n)
        fifo_count <= used);
    a_no_drop: assert property (@(posedge sram_clk) disable iff (!sram_rst_n)
        !(capture && fifo_full && !pop));

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: randomized and directed checks of sram_req_ctrl against a transaction-level model.
// An SRAM behavioural model with optional output register sits on the sram_* pins.
module tb_sram_req_ctrl;
    localparam int AW = 15, DW = 32, MW = 3, DEPTH = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          req_valid = 0, req_we = 0, rsp_ready = 1, reg_out_sel = 0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [MW-1:0] req_mode = '0;
    logic          req_ready, rsp_valid, busy, sram_wen, sram_ren, sram_reg_out;
    logic [DW-1:0] rsp_rdata, sram_d_in, sram_d_out;
    logic [AW-1:0] sram_addr;
    logic [MW-1:0] sram_c;

    always #5 clk = ~clk;

    sram_req_ctrl dut (
        .sram_clk(clk), .sram_rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .reg_out_sel(reg_out_sel), .busy(busy),
        .sram_addr(sram_addr), .sram_d_in(sram_d_in), .sram_c(sram_c),
        .sram_wen(sram_wen), .sram_ren(sram_ren), .sram_reg_out(sram_reg_out),
        .sram_d_out(sram_d_out)
    );

    // SRAM: command sampled at the edge, data after one edge, or two with reg_out.
    logic [DW-1:0] smem [16];
    logic [DW-1:0] dq, dr;
    always @(posedge clk) begin
        if (sram_wen) smem[sram_addr[3:0]] <= sram_d_in;
        if (sram_ren) dq <= smem[sram_addr[3:0]];
        dr <= dq;
    end
    assign sram_d_out = sram_reg_out ? dr : dq;

    typedef struct {
        logic [DW-1:0] data;
        int            rdy;
    } rsp_t;

    rsp_t          q[$];
    logic [DW-1:0] mem [16];
    logic [DW-1:0] last_rd = '0;
    int outstanding = 0, cyc = 0, accepts = 0, errors = 0, checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: decide handshakes from the settled inputs, step the model, then check outputs.
    task automatic cycle();
        logic acc, pop, we, exp_v;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [MW-1:0] m;
        #1;
        check("req_ready", req_ready, outstanding < DEPTH);
        acc = req_valid && req_ready;
        pop = rsp_valid && rsp_ready;
        we = req_we; a = req_addr; wd = req_wdata; m = req_mode;
        @(posedge clk);
        cyc++;
        #1;
        if (pop && q.size() > 0) begin
            last_rd = q[0].data;
            void'(q.pop_front());
            outstanding--;
        end
        if (acc) begin
            accepts++;
            if (we) mem[a[3:0]] = wd;
            else begin
                q.push_back(rsp_t'{mem[a[3:0]], cyc + (reg_out_sel ? 3 : 2)});
                outstanding++;
            end
        end
        check("sram_wen", sram_wen, acc && we);
        check("sram_ren", sram_ren, acc && !we);
        if (acc) begin
            check("sram_addr", sram_addr, a);
            check("sram_d_in", sram_d_in, wd);
            check("sram_c", sram_c, m);
        end
        check("busy", busy, outstanding != 0);
        exp_v = q.size() > 0 && q[0].rdy <= cyc;
        check("rsp_valid", rsp_valid, exp_v);
        check("rsp_rdata", rsp_rdata, exp_v ? q[0].data : last_rd);
    endtask

    task automatic req(input logic v, input logic we, input int a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        req_valid = v; req_we = we; req_addr = AW'(a); req_wdata = d; req_mode = m;
        cycle();
    endtask

    task automatic idle(input int n);
        req_valid = 0;
        rsp_ready = 1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wen"}, sram_wen, 0);
        check({tag, "_ren"}, sram_ren, 0);
        check({tag, "_addr"}, sram_addr, 0);
        check({tag, "_d_in"}, sram_d_in, 0);
        check({tag, "_c"}, sram_c, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req_ready"}, req_ready, 1);
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 16; i++) mem[i] = 'x;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1;
        check("reg_out_pin", sram_reg_out, 0);

        for (int i = 0; i < 16; i++) req(1, 1, i, 32'hA5A5_0000 ^ (32'h0101_0101 * i), MW'(i));
        idle(2);

        req(1, 1, 0, 32'h0005_FFAB, 3'b000);
        req(1, 0, 0, '0, 3'b000);
        idle(5);

        reg_out_sel = 1;
        req(1, 1, 0, 32'h0005_FFAB, 3'b000);
        req(1, 0, 0, '0, 3'b000);
        idle(6);
        check("reg_out_pin1", sram_reg_out, 1);

        req(1, 1, 2, 32'hB2, 3'b010);
        req(1, 1, 12, 32'hF, 3'b011);
        idle(2);

        reg_out_sel = 0;
        rsp_ready = 0;
        n0 = accepts;
        for (int i = 0; i < 6; i++) req(1, 0, accepts - n0, '0, '0);
        check("full_accepts", accepts - n0, 4);
        check("full_ready", req_ready, 0);
        n0 = accepts;
        rsp_ready = 1;
        req(1, 0, 4, '0, '0);
        rsp_ready = 0;
        for (int i = 0; i < 3; i++) req(1, 0, 4, '0, '0);
        check("one_credit", accepts - n0, 1);
        idle(8);

        rsp_ready = 0;
        for (int i = 0; i < 6; i++) req(1, 0, i, '0, '0);
        rsp_ready = 1;
        for (int i = 0; i < 8; i++) req(1, 0, $urandom_range(0, 15), '0, '0);
        n0 = accepts;
        for (int i = 0; i < 10; i++) req(1, 0, $urandom_range(0, 15), '0, '0);
        check("throughput", accepts - n0, 10);
        idle(8);

        for (int p = 0; p < 2; p++) begin
            reg_out_sel = p[0];
            for (int i = 0; i < 300; i++) begin
                rsp_ready = ($urandom % 4) != 0;
                req(($urandom % 3) != 0, $urandom % 2, $urandom_range(0, 15), $urandom, MW'($urandom));
            end
            idle(10);
        end

        reg_out_sel = 0;
        req(1, 0, 3, '0, '0);
        req_valid = 0;
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check_reset_outputs("mid_reset");
        q.delete();
        outstanding = 0;
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_no_rsp", rsp_valid, 0);
        rst_n = 1;
        req(1, 0, 7, '0, '0);
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
